// File: rtl/breakout_ball_engine.sv
// Per-frame paddle and ball update for the breakout game: each accepted frame pulse
// runs STEPS_PER_FRAME single-cycle sub-steps of paddle motion and subpixel ball physics.
module breakout_ball_engine #(
    parameter int SUBPIXEL_BITS       = 3,
    parameter int STEPS_PER_FRAME     = 3,
    parameter int PADDLE_LENGTH_PIXEL = 60,
    parameter int PADDLE_SPEED        = 1,
    parameter int BALL_SIZE_PIXEL     = 8,
    parameter int GAME_BEGIN_X        = 8,
    parameter int GAME_END_X          = 792,
    parameter int GAME_TOP_Y          = 8,
    parameter int PADDLE_Y            = 584,
    parameter int SCREEN_BOTTOM_Y     = 600,
    parameter int LIVES               = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START_UPDATE,
    input  logic       BTN_LEFT,
    input  logic       BTN_RIGHT,
    input  logic       BTN_RELEASE,
    output logic [9:0] PADDLE_X_PIXEL,
    output logic [9:0] BALL_X_PIXEL,
    output logic [9:0] BALL_Y_PIXEL,
    output logic [2:0] LIVES_LEFT,
    output logic       BUSY,
    output logic       UPDATE_DONE,
    output logic       GAME_OVER
);

    localparam int PW        = 10 + SUBPIXEL_BITS;
    localparam int AW        = PW + 2;
    localparam int SUB       = 1 << SUBPIXEL_BITS;
    localparam int PAD_MIN   = GAME_BEGIN_X;
    localparam int PAD_MAX   = GAME_END_X - PADDLE_LENGTH_PIXEL;
    localparam int PAD_RESET = (GAME_BEGIN_X + GAME_END_X - PADDLE_LENGTH_PIXEL) / 2;
    localparam int REST_OFF  = (PADDLE_LENGTH_PIXEL - BALL_SIZE_PIXEL) / 2;

    localparam logic signed [AW-1:0] X_MIN  = AW'(GAME_BEGIN_X * SUB);
    localparam logic signed [AW-1:0] X_MAX  = AW'((GAME_END_X - BALL_SIZE_PIXEL) * SUB);
    localparam logic signed [AW-1:0] Y_MIN  = AW'(GAME_TOP_Y * SUB);
    localparam logic signed [AW-1:0] Y_REST = AW'((PADDLE_Y - BALL_SIZE_PIXEL) * SUB);
    localparam logic signed [AW-1:0] Y_LOSS = AW'(SCREEN_BOTTOM_Y * SUB);
    localparam logic [PW-1:0]        BX_RESET = PW'((PAD_RESET + REST_OFF) * SUB);

    typedef enum logic [1:0] {S_WAIT, S_PLAY, S_LOST, S_OVER} state_e;

    state_e             state_q, state_d;
    logic [9:0]         paddle_q, paddle_d;
    logic [PW-1:0]      bx_q, bx_d, by_q, by_d;
    logic signed [4:0]  vx_q, vx_d, vy_q, vy_d;
    logic [2:0]         lives_q, lives_d;
    logic [2:0]         step_q, step_d;
    logic [1:0]         frame_q, frame_d;
    logic               busy_q, busy_d, done_q, done_d, over_q, over_d;

    logic [9:0]         paddle_mv;
    logic [10:0]        pad_inc;
    logic signed [AW-1:0] nx_s, ny_s, px_x, px_y;
    logic signed [4:0]  px_vx, px_vy;
    logic [9:0]         bpx;
    logic signed [15:0] off, off_c;
    logic [1:0]         zone;
    logic               overlap, hit, px_lost;

    // Shared by the launch direction (frame counter) and the paddle hit zone.
    function automatic logic signed [4:0] dir_vx(input logic [1:0] sel);
        case (sel)
            2'd0:    dir_vx = -5'sd2;
            2'd1:    dir_vx = -5'sd1;
            2'd2:    dir_vx = 5'sd1;
            default: dir_vx = 5'sd2;
        endcase
    endfunction

    always_comb begin : frame_seq
        busy_d  = busy_q;
        step_d  = step_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        if (!busy_q && START_UPDATE) begin
            busy_d  = 1'b1;
            step_d  = 3'd0;
            frame_d = frame_q + 2'd1;
        end else if (busy_q) begin
            if (step_q == 3'(STEPS_PER_FRAME - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                step_d = step_q + 3'd1;
            end
        end
    end

    always_comb begin : paddle_math
        paddle_mv = paddle_q;
        pad_inc   = {1'b0, paddle_q} + 11'(PADDLE_SPEED);
        if (BTN_LEFT && !BTN_RIGHT) begin
            if ({1'b0, paddle_q} < 11'(PAD_MIN + PADDLE_SPEED)) paddle_mv = 10'(PAD_MIN);
            else                                                paddle_mv = paddle_q - 10'(PADDLE_SPEED);
        end else if (BTN_RIGHT && !BTN_LEFT) begin
            if (pad_inc > 11'(PAD_MAX)) paddle_mv = 10'(PAD_MAX);
            else                        paddle_mv = pad_inc[9:0];
        end
    end

    always_comb begin : ball_math
        nx_s  = $signed({2'b00, bx_q}) + $signed({{(AW-5){vx_q[4]}}, vx_q});
        ny_s  = $signed({2'b00, by_q}) + $signed({{(AW-5){vy_q[4]}}, vy_q});
        px_x  = nx_s;
        px_vx = vx_q;
        if (nx_s < X_MIN) begin
            px_x  = X_MIN;
            px_vx = -vx_q;
        end else if (nx_s > X_MAX) begin
            px_x  = X_MAX;
            px_vx = -vx_q;
        end
        px_y  = ny_s;
        px_vy = vy_q;
        if (ny_s < Y_MIN) begin
            px_y  = Y_MIN;
            px_vy = -vy_q;
        end
        bpx     = px_x[PW-1:SUBPIXEL_BITS];
        overlap = ({1'b0, bpx} + 11'(BALL_SIZE_PIXEL) > {1'b0, paddle_q}) &&
                  ({1'b0, bpx} < {1'b0, paddle_q} + 11'(PADDLE_LENGTH_PIXEL));
        off     = $signed({6'd0, bpx}) - $signed({6'd0, paddle_q}) + 16'(BALL_SIZE_PIXEL / 2);
        if (off < 16'sd0)                               off_c = 16'sd0;
        else if (off > 16'(PADDLE_LENGTH_PIXEL - 1))    off_c = 16'(PADDLE_LENGTH_PIXEL - 1);
        else                                            off_c = off;
        if ((off_c * 16'sd4) < 16'(PADDLE_LENGTH_PIXEL))          zone = 2'd0;
        else if ((off_c * 16'sd4) < 16'(2 * PADDLE_LENGTH_PIXEL)) zone = 2'd1;
        else if ((off_c * 16'sd4) < 16'(3 * PADDLE_LENGTH_PIXEL)) zone = 2'd2;
        else                                                      zone = 2'd3;
        // Crossing test on the ball bottom edge so a fast ball cannot tunnel through.
        hit = (vy_q > 5'sd0) && ($signed({2'b00, by_q}) <= Y_REST) && (ny_s > Y_REST) && overlap;
        if (hit) begin
            px_y  = Y_REST;
            px_vy = -vy_q;
            px_vx = dir_vx(zone);
        end
        px_lost = (px_y >= Y_LOSS);
    end

    always_comb begin : next_state
        state_d = state_q;
        if (busy_q) begin
            case (state_q)
                S_WAIT:  if (BTN_RELEASE) state_d = S_PLAY;
                S_PLAY:  if (px_lost) state_d = S_LOST;
                S_LOST:  state_d = (lives_q == 3'd1) ? S_OVER : S_WAIT;
                default: state_d = S_OVER;
            endcase
        end
    end

    always_comb begin : datapath
        paddle_d = paddle_q;
        bx_d     = bx_q;
        by_d     = by_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        lives_d  = lives_q;
        over_d   = over_q;
        if (busy_q) begin
            case (state_q)
                S_WAIT: begin
                    // Resting ball stays centred on the paddle as it moves this sub-step.
                    paddle_d = paddle_mv;
                    bx_d     = {paddle_mv + 10'(REST_OFF), {SUBPIXEL_BITS{1'b0}}};
                    by_d     = Y_REST[PW-1:0];
                    vx_d     = 5'sd0;
                    vy_d     = 5'sd0;
                    if (BTN_RELEASE) begin
                        vx_d = dir_vx(frame_q);
                        vy_d = -5'sd4;
                    end
                end
                S_PLAY: begin
                    paddle_d = paddle_mv;
                    bx_d     = px_x[PW-1:0];
                    by_d     = px_y[PW-1:0];
                    vx_d     = px_vx;
                    vy_d     = px_vy;
                end
                S_LOST: begin
                    paddle_d = paddle_mv;
                    vx_d     = 5'sd0;
                    vy_d     = 5'sd0;
                    lives_d  = lives_q - 3'd1;
                    if (lives_q == 3'd1) over_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_WAIT;
            paddle_q <= 10'(PAD_RESET);
            bx_q     <= BX_RESET;
            by_q     <= Y_REST[PW-1:0];
            vx_q     <= 5'sd0;
            vy_q     <= 5'sd0;
            lives_q  <= 3'(LIVES);
            step_q   <= 3'd0;
            frame_q  <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            paddle_q <= paddle_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            lives_q  <= lives_d;
            step_q   <= step_d;
            frame_q  <= frame_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            over_q   <= over_d;
        end
    end

    assign PADDLE_X_PIXEL = paddle_q;
    assign BALL_X_PIXEL   = bx_q[PW-1:SUBPIXEL_BITS];
    assign BALL_Y_PIXEL   = by_q[PW-1:SUBPIXEL_BITS];
    assign LIVES_LEFT     = lives_q;
    assign BUSY           = busy_q;
    assign UPDATE_DONE    = done_q;
    assign GAME_OVER      = over_q;

endmodule
